match_scheduler: RTL and testbench
==================================

# match_scheduler

Match-level controller that sequences the `fightingGame` core through turns, rounds and a best-of-N match. Each player submits an action with a valid/ready handshake. The block latches both actions, applies a no-op for any player who misses the turn timeout, and strobes them into the core with a one-cycle `actionEnable`. It then samples the core's win flags, keeps round scores, and resets the core between rounds until one player has won the match.

## Interface
- `ROUNDS_TO_WIN`, default 2: rounds a player must win to take the match (1..3).
- `TURN_TIMEOUT`, default 15: cycles COLLECT waits for actions before defaulting (2..255).
- `clk` input 1: system clock, rising edge.
- `resetGame` input 1: synchronous, active-high reset of this block.
- `p1Valid` input 1: player 1 offers `p1Action`.
- `p1Action` input 3: player 1 action code.
- `p1Ready` output 1: block will accept player 1's action this cycle.
- `p2Valid` input 1: player 2 offers `p2Action`.
- `p2Action` input 3: player 2 action code.
- `p2Ready` output 1: block will accept player 2's action this cycle.
- `firstWin` input 1: core flag, player 1 has won the round.
- `secondWin` input 1: core flag, player 2 has won the round.
- `newMatch` input 1: start a new match; honoured only in MATCH_OVER.
- `action1` output 3: action presented to the core for player 1.
- `action2` output 3: action presented to the core for player 2.
- `actionEnable` output 1: one-cycle strobe that commits `action1`/`action2`.
- `roundReset` output 1: one-cycle active-high pulse to the core's reset input.
- `p1Rounds` output 2: rounds won by player 1.
- `p2Rounds` output 2: rounds won by player 2.
- `turnCount` output 8: turns in the current round, saturating at 255.
- `matchOver` output 1: match finished.
- `matchWinner` output 2: 01 = player 1, 10 = player 2, 00 = undecided.

## Operation
- Action code 3'b000 is the no-op. It is the default for any player with no action when the timeout fires.
- FSM states: ROUND_START, COLLECT, FIRE, SETTLE, CHECK, MATCH_OVER.
- **ROUND_START** (1 cycle):
  - `roundReset`=1.
  - Clears both latched-action flags, the timer and `turnCount`.
  - Next state: COLLECT.
- **COLLECT**:
  - `pNReady`=1 while player N has no latched action.
  - `pNValid && pNReady` latches `pNAction` and sets player N's latched flag. Ready drops the next cycle.
  - Further valids from a latched player are ignored.
  - Timer increments every COLLECT cycle.
  - Exit to FIRE when both players are latched, or when the timer equals `TURN_TIMEOUT`-1. On a timeout exit, every unlatched player gets 3'b000.
  - A handshake in the timeout cycle is accepted and takes priority over the default.
- **FIRE** (1 cycle):
  - `actionEnable`=1.
  - `action1`/`action2` show the latched values. They hold from FIRE through CHECK and return to 000 afterwards.
- **SETTLE** (1 cycle): lets the core's registered health and win logic update.
- **CHECK** (1 cycle) samples `firstWin`/`secondWin`:
  - Both 1: draw. No score change; go to ROUND_START.
  - `firstWin` only: `p1Rounds`+1. Go to MATCH_OVER if it now equals `ROUNDS_TO_WIN`, else ROUND_START.
  - `secondWin` only: same as above, for `p2Rounds`.
  - Neither: `turnCount`+1 (saturating), clear latched flags and timer, go to COLLECT.
- **MATCH_OVER**:
  - `matchOver`=1 and `matchWinner` set; both hold.
  - Ready outputs are 0 and all valids are ignored.
  - `newMatch`=1 clears scores, `matchOver` and `matchWinner`, then goes to ROUND_START.
- `newMatch` outside MATCH_OVER is ignored.
- Round counters are 2 bits and never exceed `ROUNDS_TO_WIN`.

## Timing
- **Reset:** `resetGame`=1 at an edge forces the following values at that edge, from any state including mid-turn:
  - state ROUND_START;
  - `p1Ready`/`p2Ready`=0, `actionEnable`=0, `action1`/`action2`=000;
  - `roundReset`=0, `p1Rounds`/`p2Rounds`=0, `turnCount`=0;
  - `matchOver`=0, `matchWinner`=00.
- **First cycle after reset:** `roundReset`=1. Ready outputs rise the cycle after that.
- **Best-case turn latency:** both players handshake in the first COLLECT cycle, `actionEnable` follows in the next cycle, and CHECK comes 2 cycles after FIRE. That is 4 cycles COLLECT→COLLECT.
- **Timeout turn:** exactly `TURN_TIMEOUT` COLLECT cycles, then FIRE.
- **Ready timing:** ready is a registered function of state and latched flags. It never depends combinationally on valid.
- **Win flags:** sampled only in CHECK. Flags during other states have no effect.
- **roundReset vs actionEnable:** mutually exclusive by construction.

## Test plan
- **Reset and first pulse:** hold reset 2 cycles, then release → all outputs at reset values, `roundReset` high exactly 1 cycle, ready outputs high the next cycle.
- **Normal turn:** p1 110 and p2 100, both valid in the same COLLECT cycle → `actionEnable` high for 1 cycle with `action1`=110 and `action2`=100, `turnCount` 0→1.
- **Timeout:** only p1 sends 001; p2 silent → FIRE after 15 COLLECT cycles with `action2`=000; `p2Ready` falls when leaving COLLECT.
- **Late handshake:** p2 valid exactly on timeout cycle 15 → `action2` equals p2's code, not 000.
- **Match:** `firstWin` in two CHECKs with a round in between → `p1Rounds`=2, `matchOver`=1, `matchWinner`=01, `roundReset` pulsed after round 1. `newMatch` then clears scores and pulses `roundReset`.
- **Draw and mid-turn reset:** both win flags in CHECK → scores unchanged, new round starts. Reset asserted mid-COLLECT with p1 latched → next FIRE carries no stale action.

Source files
------------

// File: rtl/match_scheduler.sv
// Match-level sequencer for the fightingGame core: gathers both players' actions each turn,
// strobes them into the core, scores rounds and stops once a player reaches ROUNDS_TO_WIN.
module match_scheduler #(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int TURN_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       resetGame,
    input  logic       p1Valid,
    input  logic [2:0] p1Action,
    output logic       p1Ready,
    input  logic       p2Valid,
    input  logic [2:0] p2Action,
    output logic       p2Ready,
    input  logic       firstWin,
    input  logic       secondWin,
    input  logic       newMatch,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       actionEnable,
    output logic       roundReset,
    output logic [1:0] p1Rounds,
    output logic [1:0] p2Rounds,
    output logic [7:0] turnCount,
    output logic       matchOver,
    output logic [1:0] matchWinner
);

    localparam logic [1:0] RTW      = ROUNDS_TO_WIN[1:0];
    localparam logic [7:0] TMO_LAST = 8'(TURN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ROUND_START,
        COLLECT,
        FIRE,
        SETTLE,
        CHECK,
        MATCH_OVER
    } state_t;

    state_t     state_q, state_d;
    logic       lat1_q, lat1_d, lat2_q, lat2_d;
    logic [2:0] act1_q, act1_d, act2_q, act2_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] turns_q, turns_d;
    logic [1:0] p1r_q, p1r_d, p2r_q, p2r_d;
    logic [1:0] winner_q, winner_d;
    logic       hs1, hs2, show;

    // Ready is decoded from registered state only, never from valid.
    assign p1Ready = (state_q == COLLECT) && !lat1_q;
    assign p2Ready = (state_q == COLLECT) && !lat2_q;
    assign hs1     = p1Valid && p1Ready;
    assign hs2     = p2Valid && p2Ready;

    // An unlatched player presents the no-op, so a timed-out turn needs no extra clearing.
    assign show         = state_q inside {FIRE, SETTLE, CHECK};
    assign action1      = (show && lat1_q) ? act1_q : 3'b000;
    assign action2      = (show && lat2_q) ? act2_q : 3'b000;
    assign actionEnable = (state_q == FIRE);
    // Masked by reset so the pulse appears only in the first cycle with reset released.
    assign roundReset   = (state_q == ROUND_START) && !resetGame;
    assign matchOver    = (state_q == MATCH_OVER);
    assign matchWinner  = winner_q;
    assign p1Rounds     = p1r_q;
    assign p2Rounds     = p2r_q;
    assign turnCount    = turns_q;

    always_comb begin
        state_d  = state_q;
        lat1_d   = lat1_q;
        lat2_d   = lat2_q;
        act1_d   = act1_q;
        act2_d   = act2_q;
        timer_d  = timer_q;
        turns_d  = turns_q;
        p1r_d    = p1r_q;
        p2r_d    = p2r_q;
        winner_d = winner_q;
        case (state_q)
            ROUND_START: begin
                lat1_d  = 1'b0;
                lat2_d  = 1'b0;
                timer_d = 8'd0;
                turns_d = 8'd0;
                state_d = COLLECT;
            end
            COLLECT: begin
                if (hs1) begin
                    lat1_d = 1'b1;
                    act1_d = p1Action;
                end
                if (hs2) begin
                    lat2_d = 1'b1;
                    act2_d = p2Action;
                end
                timer_d = timer_q + 8'd1;
                if ((lat1_d && lat2_d) || (timer_q == TMO_LAST)) state_d = FIRE;
            end
            FIRE:   state_d = SETTLE;
            SETTLE: state_d = CHECK;
            CHECK: begin
                if (firstWin && secondWin) begin
                    state_d = ROUND_START;
                end else if (firstWin) begin
                    p1r_d = p1r_q + 2'd1;
                    if (p1r_d == RTW) begin
                        winner_d = 2'b01;
                        state_d  = MATCH_OVER;
                    end else begin
                        state_d = ROUND_START;
                    end
                end else if (secondWin) begin
                    p2r_d = p2r_q + 2'd1;
                    if (p2r_d == RTW) begin
                        winner_d = 2'b10;
                        state_d  = MATCH_OVER;
                    end else begin
                        state_d = ROUND_START;
                    end
                end else begin
                    turns_d = (turns_q == 8'hFF) ? turns_q : turns_q + 8'd1;
                    lat1_d  = 1'b0;
                    lat2_d  = 1'b0;
                    timer_d = 8'd0;
                    state_d = COLLECT;
                end
            end
            MATCH_OVER: begin
                if (newMatch) begin
                    p1r_d    = 2'd0;
                    p2r_d    = 2'd0;
                    winner_d = 2'b00;
                    state_d  = ROUND_START;
                end
            end
            default: state_d = ROUND_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetGame) begin
            state_q  <= ROUND_START;
            lat1_q   <= 1'b0;
            lat2_q   <= 1'b0;
            act1_q   <= 3'b000;
            act2_q   <= 3'b000;
            timer_q  <= 8'd0;
            turns_q  <= 8'd0;
            p1r_q    <= 2'd0;
            p2r_q    <= 2'd0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            lat1_q   <= lat1_d;
            lat2_q   <= lat2_d;
            act1_q   <= act1_d;
            act2_q   <= act2_d;
            timer_q  <= timer_d;
            turns_q  <= turns_d;
            p1r_q    <= p1r_d;
            p2r_q    <= p2r_d;
            winner_q <= winner_d;
        end
    end

endmodule

// File: tb/tb_match_scheduler.sv
// Scoreboard bench for match_scheduler: a turn-level model predicts each cycle's outputs and the
// roundReset/actionEnable events; a negedge monitor compares them against the DUT.
module tb_match_scheduler;

    localparam int T   = 15;
    localparam int RTW = 2;

    localparam int OC_NONE = 0;
    localparam int OC_P1   = 1;
    localparam int OC_P2   = 2;
    localparam int OC_DRAW = 3;

    localparam int EV_FIRE = 1;  // {roundReset, actionEnable} == 2'b01
    localparam int EV_RR   = 2;  // {roundReset, actionEnable} == 2'b10

    logic       clk = 1'b0;
    logic       resetGame;
    logic       p1Valid, p2Valid;
    logic [2:0] p1Action, p2Action;
    logic       p1Ready, p2Ready;
    logic       firstWin, secondWin, newMatch;
    logic [2:0] action1, action2;
    logic       actionEnable, roundReset;
    logic [1:0] p1Rounds, p2Rounds;
    logic [7:0] turnCount;
    logic       matchOver;
    logic [1:0] matchWinner;

    match_scheduler #(.ROUNDS_TO_WIN(RTW), .TURN_TIMEOUT(T)) dut (
        .clk(clk), .resetGame(resetGame),
        .p1Valid(p1Valid), .p1Action(p1Action), .p1Ready(p1Ready),
        .p2Valid(p2Valid), .p2Action(p2Action), .p2Ready(p2Ready),
        .firstWin(firstWin), .secondWin(secondWin), .newMatch(newMatch),
        .action1(action1), .action2(action2),
        .actionEnable(actionEnable), .roundReset(roundReset),
        .p1Rounds(p1Rounds), .p2Rounds(p2Rounds), .turnCount(turnCount),
        .matchOver(matchOver), .matchWinner(matchWinner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] a1;
        logic [2:0] a2;
    } ev_t;

    ev_t evq[$];
    ev_t ev;

    int n_err = 0;
    int n_chk = 0;
    bit mon_en = 0;

    // Model state (takes effect on the next cycle) and this cycle's expectations.
    int         m_p1r, m_p2r, m_turns;
    logic       m_mo;
    logic [1:0] m_win;
    logic       exp_r1, exp_r2, exp_mo;
    logic [2:0] exp_a1, exp_a2;
    int         exp_p1r, exp_p2r, exp_turns;
    logic [1:0] exp_win;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("p1Ready", p1Ready, exp_r1);
            chk("p2Ready", p2Ready, exp_r2);
            chk("action1", action1, exp_a1);
            chk("action2", action2, exp_a2);
            chk("p1Rounds", p1Rounds, exp_p1r);
            chk("p2Rounds", p2Rounds, exp_p2r);
            chk("turnCount", turnCount, exp_turns);
            chk("matchOver", matchOver, exp_mo);
            chk("matchWinner", matchWinner, exp_win);
            if (roundReset || actionEnable) begin
                if (evq.size() == 0) begin
                    chk("spurious_event", {roundReset, actionEnable}, 0);
                end else begin
                    ev = evq.pop_front();
                    chk("event_kind", {roundReset, actionEnable}, ev.kind);
                    chk("event_cycle", cyc, ev.cyc);
                    if (ev.kind == EV_FIRE) begin
                        chk("fire_action1", action1, ev.a1);
                        chk("fire_action2", action2, ev.a2);
                    end
                end
            end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
                ev = evq.pop_front();
                chk("missed_event", {roundReset, actionEnable}, ev.kind);
            end
        end
    end

    task automatic zero_model();
        m_p1r = 0; m_p2r = 0; m_turns = 0; m_mo = 1'b0; m_win = 2'b00;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        exp_r1 = 1'b0; exp_r2 = 1'b0; exp_a1 = 3'b000; exp_a2 = 3'b000;
        exp_p1r = m_p1r; exp_p2r = m_p2r; exp_turns = m_turns;
        exp_mo = m_mo; exp_win = m_win;
    endtask

    // Junk on every input the current state should ignore.
    task automatic drive_idle();
        p1Valid   = 1'($urandom); p1Action = 3'($urandom);
        p2Valid   = 1'($urandom); p2Action = 3'($urandom);
        firstWin  = 1'($urandom); secondWin = 1'($urandom);
        newMatch  = 1'($urandom);
    endtask

    task automatic round_start_body();
        ev_t e;
        drive_idle();
        e.kind = EV_RR; e.cyc = cyc; e.a1 = 3'b000; e.a2 = 3'b000;
        evq.push_back(e);
        m_turns = 0;
    endtask

    task automatic do_round_start();
        begin_cycle();
        round_start_body();
    endtask

    task automatic do_match_over();
        int n;
        n = $urandom_range(1, 4);
        repeat (n) begin
            begin_cycle(); drive_idle(); newMatch = 1'b0;
        end
        begin_cycle(); drive_idle(); newMatch = 1'b1;
        m_p1r = 0; m_p2r = 0; m_mo = 1'b0; m_win = 2'b00;
        do_round_start();
    endtask

    // One turn starting at the first COLLECT cycle; k >= T means the player never offers.
    task automatic do_turn(input int k1, input logic [2:0] c1, input int k2, input logic [2:0] c2,
                           input int oc);
        int ex;
        logic [2:0] a1, a2;
        ev_t e;
        ex = (k1 < T && k2 < T) ? ((k1 > k2) ? k1 : k2) : T - 1;
        a1 = (k1 < T) ? c1 : 3'b000;
        a2 = (k2 < T) ? c2 : 3'b000;
        for (int i = 0; i <= ex; i++) begin
            begin_cycle(); drive_idle();
            if (i == 0) begin
                e.kind = EV_FIRE; e.cyc = cyc + ex + 1; e.a1 = a1; e.a2 = a2;
                evq.push_back(e);
            end
            p1Valid  = (i == k1) ? 1'b1 : ((i > k1) ? 1'($urandom) : 1'b0);
            p1Action = (i == k1) ? c1 : 3'($urandom);
            p2Valid  = (i == k2) ? 1'b1 : ((i > k2) ? 1'($urandom) : 1'b0);
            p2Action = (i == k2) ? c2 : 3'($urandom);
            exp_r1 = (i <= k1);
            exp_r2 = (i <= k2);
        end
        repeat (2) begin
            begin_cycle(); drive_idle(); exp_a1 = a1; exp_a2 = a2;
        end
        begin_cycle(); drive_idle(); exp_a1 = a1; exp_a2 = a2;
        firstWin  = (oc == OC_P1 || oc == OC_DRAW);
        secondWin = (oc == OC_P2 || oc == OC_DRAW);
        case (oc)
            OC_DRAW: do_round_start();
            OC_P1: begin
                m_p1r++;
                if (m_p1r == RTW) begin m_mo = 1'b1; m_win = 2'b01; do_match_over(); end
                else do_round_start();
            end
            OC_P2: begin
                m_p2r++;
                if (m_p2r == RTW) begin m_mo = 1'b1; m_win = 2'b10; do_match_over(); end
                else do_round_start();
            end
            default: m_turns = (m_turns == 255) ? 255 : m_turns + 1;
        endcase
    endtask

    initial begin
        int r;
        resetGame = 1'b1;
        p1Valid = 1'b0; p2Valid = 1'b0; p1Action = 3'b000; p2Action = 3'b000;
        firstWin = 1'b0; secondWin = 1'b0; newMatch = 1'b0;
        zero_model();

        // Reset held for two edges, then the roundReset pulse.
        begin_cycle(); drive_idle();
        mon_en = 1'b1;
        begin_cycle(); resetGame = 1'b0; round_start_body();

        do_turn(0, 3'b110, 0, 3'b100, OC_NONE);     // normal turn
        do_turn(0, 3'b001, T, 3'b000, OC_NONE);     // p2 times out
        do_turn(3, 3'b010, T - 1, 3'b101, OC_NONE); // p2 handshakes in the timeout cycle
        do_turn(1, 3'b011, 0, 3'b111, OC_P1);       // round 1 to p1
        do_turn(0, 3'b100, 2, 3'b001, OC_NONE);
        do_turn(0, 3'b101, 0, 3'b010, OC_P1);       // match to p1, then newMatch

        do_turn(0, 3'b001, 0, 3'b001, OC_P2);
        do_turn(2, 3'b110, 1, 3'b011, OC_DRAW);     // draw keeps the score

        // Mid-turn reset with p1 already latched.
        begin_cycle(); drive_idle();
        p1Valid = 1'b1; p1Action = 3'b111; p2Valid = 1'b0;
        exp_r1 = 1'b1; exp_r2 = 1'b1;
        begin_cycle(); drive_idle();
        p1Valid = 1'b0; p2Valid = 1'b0; exp_r1 = 1'b0; exp_r2 = 1'b1;
        resetGame = 1'b1; zero_model();
        begin_cycle(); drive_idle();
        begin_cycle(); resetGame = 1'b0; round_start_body();
        do_turn(T, 3'b000, 1, 3'b011, OC_NONE);     // no stale 111 on action1

        // turnCount saturation, then p2 takes the match.
        for (int n = 0; n < 258; n++) do_turn(0, 3'($urandom), 0, 3'($urandom), OC_NONE);
        do_turn(0, 3'b010, 0, 3'b010, OC_P2);
        do_turn(0, 3'b001, 0, 3'b110, OC_P2);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            do_turn($urandom_range(0, T + 2), 3'($urandom), $urandom_range(0, T + 2), 3'($urandom),
                    (r == 6) ? OC_P1 : (r == 7) ? OC_P2 : (r == 8) ? OC_DRAW : OC_NONE);
        end

        @(negedge clk);
        #1;
        chk("pending_events", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
